// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multicycle_control: multi-cycle MIPS sequencer, req/ack memory FSM |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 equal,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_en,
  output logic                 pc_en,
  output logic                 pc_sel,
  output logic [3:0]           alu_op,
  output logic [1:0]           alu_a_sel,
  output logic [1:0]           alu_b_sel,
  output logic                 rd_en,
  output logic                 rd_addr_sel,
  output logic                 rd_data_sel,
  output logic                 illegal,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] instr_count
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                         OP_LW    = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_ADD = 6'h20,
                         FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25, FN_SLT = 6'h2A;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_SLT = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [1:0] A_PC = 2'd0, A_REG = 2'd1, A_SHAMT = 2'd2;
  localparam logic [1:0] B_REG = 2'd0, B_FOUR = 2'd1, B_IMM = 2'd2, B_IMM_SH2 = 2'd3;
  localparam logic RD_SEL_RT = 1'b0, RD_SEL_RD = 1'b1;
  localparam logic RD_DATA_SEL_ALU = 1'b0, RD_DATA_SEL_MEM = 1'b1;
  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6
  } state_t;

  state_t               r_state, w_next;
  logic [TW-1:0]        r_timer;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_bus_error;
  logic                 w_retire, w_op_valid, w_funct_valid, w_shift;
  logic [3:0]           w_funct_alu;

  assign bus_error   = r_bus_error;
  assign instr_count = r_count;
  assign w_op_valid  = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_ADDI) ||
                       (opcode == OP_LW)    || (opcode == OP_SW);

  always_comb begin
    w_funct_valid = 1'b1;
    w_shift       = 1'b0;
    w_funct_alu   = ALU_ADD;
    case (funct)
      FN_ADD:  w_funct_alu = ALU_ADD;
      FN_SUB:  w_funct_alu = ALU_SUB;
      FN_AND:  w_funct_alu = ALU_AND;
      FN_OR:   w_funct_alu = ALU_OR;
      FN_SLT:  w_funct_alu = ALU_SLT;
      FN_SLL:  begin w_funct_alu = ALU_SLL; w_shift = 1'b1; end
      FN_SRL:  begin w_funct_alu = ALU_SRL; w_shift = 1'b1; end
      FN_SRA:  begin w_funct_alu = ALU_SRA; w_shift = 1'b1; end
      default: w_funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = 1'b0;
    alu_op       = ALU_ADD;
    alu_a_sel    = A_PC;
    alu_b_sel    = B_REG;
    rd_en        = 1'b0;
    rd_addr_sel  = RD_SEL_RT;
    rd_data_sel  = RD_DATA_SEL_ALU;
    illegal      = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_b_sel = B_FOUR;
        if (mem_ack) begin
          ir_en  = 1'b1;
          pc_en  = 1'b1;
          w_next = S_DECODE;
        end else if (r_timer == TIMER_LAST) begin
          w_next = S_HALT;
        end
      end
      S_DECODE: begin
        // ALU-out captures PC+4+(imm<<2) here so BEQ can load it in EXEC
        alu_b_sel = B_IMM_SH2;
        if (w_op_valid) begin
          w_next = S_EXEC;
        end else begin
          illegal = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_EXEC: begin
        w_next = S_FETCH;
        case (opcode)
          OP_RTYPE: begin
            if (w_funct_valid) begin
              alu_a_sel = w_shift ? A_SHAMT : A_REG;
              alu_op    = w_funct_alu;
              w_next    = S_WB;
            end else begin
              illegal = 1'b1;
            end
          end
          OP_ADDI, OP_LW, OP_SW: begin
            alu_a_sel = A_REG;
            alu_b_sel = B_IMM;
            w_next    = (opcode == OP_ADDI) ? S_WB : S_MEM;
          end
          OP_BEQ: begin
            alu_op    = ALU_SUB;
            alu_a_sel = A_REG;
            pc_en     = equal;
            pc_sel    = 1'b1;
            w_retire  = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_SW);
        if (mem_ack) begin
          if (opcode == OP_LW) begin
            w_next = S_WB;
          end else begin
            w_next   = S_FETCH;
            w_retire = (opcode == OP_SW);
          end
        end else if (r_timer == TIMER_LAST) begin
          w_next = S_HALT;
        end
      end
      S_WB: begin
        rd_en       = 1'b1;
        rd_addr_sel = (opcode == OP_RTYPE) ? RD_SEL_RD : RD_SEL_RT;
        rd_data_sel = (opcode == OP_LW) ? RD_DATA_SEL_MEM : RD_DATA_SEL_ALU;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_HALT: ;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_count     <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_next;
      // Timer runs only while a request waits; any other cycle leaves it clear for the next entry
      if (mem_req && !mem_ack) r_timer <= r_timer + TW'(1);
      else                     r_timer <= '0;
      if (w_retire) r_count <= r_count + CNT_WIDTH'(1);
      if (w_next == S_HALT) r_bus_error <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// Directed bench for multicycle_control: vector table plus timeout/reset sequences.
module tb_multicycle_control;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd5;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] opcode, funct;
  logic equal, mem_ack;

  logic mem_req, mem_we, mem_addr_sel, ir_en, pc_en, pc_sel, rd_en, rd_addr_sel, rd_data_sel;
  logic illegal, bus_error;
  logic [3:0] alu_op;
  logic [1:0] alu_a_sel, alu_b_sel;
  logic [31:0] instr_count;

  logic t_mem_req, t_mem_we, t_mem_addr_sel, t_ir_en, t_pc_en, t_pc_sel, t_rd_en;
  logic t_rd_addr_sel, t_rd_data_sel, t_illegal, t_bus_error;
  logic [3:0] t_alu_op;
  logic [1:0] t_alu_a_sel, t_alu_b_sel;
  logic [1:0] t_instr_count;

  logic [18:0] act1, act2;
  assign act1 = {mem_req, mem_we, mem_addr_sel, ir_en, pc_en, pc_sel, alu_op, alu_a_sel,
                 alu_b_sel, rd_en, rd_addr_sel, rd_data_sel, illegal, bus_error};
  assign act2 = {t_mem_req, t_mem_we, t_mem_addr_sel, t_ir_en, t_pc_en, t_pc_sel, t_alu_op,
                 t_alu_a_sel, t_alu_b_sel, t_rd_en, t_rd_addr_sel, t_rd_data_sel, t_illegal,
                 t_bus_error};

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .equal(equal), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_en(ir_en),
    .pc_en(pc_en), .pc_sel(pc_sel), .alu_op(alu_op), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .rd_en(rd_en), .rd_addr_sel(rd_addr_sel),
    .rd_data_sel(rd_data_sel), .illegal(illegal), .bus_error(bus_error),
    .instr_count(instr_count)
  );

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .equal(equal), .mem_ack(mem_ack),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr_sel(t_mem_addr_sel), .ir_en(t_ir_en),
    .pc_en(t_pc_en), .pc_sel(t_pc_sel), .alu_op(t_alu_op), .alu_a_sel(t_alu_a_sel),
    .alu_b_sel(t_alu_b_sel), .rd_en(t_rd_en), .rd_addr_sel(t_rd_addr_sel),
    .rd_data_sel(t_rd_data_sel), .illegal(t_illegal), .bus_error(t_bus_error),
    .instr_count(t_instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        eq;
    logic        ack;
    logic [18:0] exp;
    int          cnt;
  } vec_t;
  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [18:0] ov(input logic req, we, asel, ir, pc, pcs,
                                     input logic [3:0] op, input logic [1:0] a, b,
                                     input logic rd, rda, rdd, ill, berr);
    return {req, we, asel, ir, pc, pcs, op, a, b, rd, rda, rdd, ill, berr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, fn, input logic eq, ack, input logic [18:0] e,
                     input int c);
    vecs.push_back('{op, fn, eq, ack, e, c});
  endtask

  task automatic drive(input logic [5:0] op, fn, input logic eq, ack);
    opcode = op; funct = fn; equal = eq; mem_ack = ack;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    opcode = '0; funct = '0; equal = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] Z, F1, F0, DEC, DECI, EXA, EXS, EXI, EXB1, EXB0, EXL, ML, MS, WR, WI, WL, H;
    Z    = '0;
    F1   = ov(1, 0, 0, 1, 1, 0, ALU_ADD, 2'd0, 2'd1, 0, 0, 0, 0, 0);
    F0   = ov(1, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd1, 0, 0, 0, 0, 0);
    DEC  = ov(0, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd3, 0, 0, 0, 0, 0);
    DECI = ov(0, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd3, 0, 0, 0, 1, 0);
    EXA  = ov(0, 0, 0, 0, 0, 0, ALU_ADD, 2'd1, 2'd0, 0, 0, 0, 0, 0);
    EXS  = ov(0, 0, 0, 0, 0, 0, ALU_SLL, 2'd2, 2'd0, 0, 0, 0, 0, 0);
    EXI  = ov(0, 0, 0, 0, 0, 0, ALU_ADD, 2'd1, 2'd2, 0, 0, 0, 0, 0);
    EXB1 = ov(0, 0, 0, 0, 1, 1, ALU_SUB, 2'd1, 2'd0, 0, 0, 0, 0, 0);
    EXB0 = ov(0, 0, 0, 0, 0, 1, ALU_SUB, 2'd1, 2'd0, 0, 0, 0, 0, 0);
    EXL  = ov(0, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 0, 0, 0, 1, 0);
    ML   = ov(1, 0, 1, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 0, 0, 0, 0, 0);
    MS   = ov(1, 1, 1, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 0, 0, 0, 0, 0);
    WR   = ov(0, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 1, 1, 0, 0, 0);
    WI   = ov(0, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 1, 0, 0, 0, 0);
    WL   = ov(0, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 1, 0, 1, 0, 0);
    H    = ov(0, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 0, 0, 0, 0, 1);

    add(6'h00, 6'h00, 0, 0, Z, 0);                                    // IDLE
    add(6'h00, 6'h20, 0, 1, F1, 0); add(6'h00, 6'h20, 0, 0, DEC, 0);  // ADD
    add(6'h00, 6'h20, 0, 0, EXA, 0); add(6'h00, 6'h20, 0, 0, WR, 0);
    for (int k = 0; k < 3; k++) add(6'h23, 6'h00, 0, 0, F0, 1);       // LW, 3 waits each side
    add(6'h23, 6'h00, 0, 1, F1, 1); add(6'h23, 6'h00, 0, 1, DEC, 1);
    add(6'h23, 6'h00, 0, 0, EXI, 1);
    for (int k = 0; k < 3; k++) add(6'h23, 6'h00, 0, 0, ML, 1);
    add(6'h23, 6'h00, 0, 1, ML, 1); add(6'h23, 6'h00, 0, 0, WL, 1);
    add(6'h04, 6'h00, 1, 1, F1, 2); add(6'h04, 6'h00, 1, 0, DEC, 2);  // BEQ taken
    add(6'h04, 6'h00, 1, 0, EXB1, 2);
    add(6'h04, 6'h00, 0, 1, F1, 3); add(6'h04, 6'h00, 0, 0, DEC, 3);  // BEQ not taken
    add(6'h04, 6'h00, 0, 0, EXB0, 3);
    add(6'h3F, 6'h00, 0, 1, F1, 4); add(6'h3F, 6'h00, 0, 0, DECI, 4); // bad opcode
    add(6'h00, 6'h3F, 0, 1, F1, 4); add(6'h00, 6'h3F, 0, 0, DEC, 4);  // bad funct
    add(6'h00, 6'h3F, 0, 0, EXL, 4);
    add(6'h2B, 6'h00, 0, 1, F1, 4); add(6'h2B, 6'h00, 0, 0, DEC, 4);  // SW
    add(6'h2B, 6'h00, 0, 0, EXI, 4); add(6'h2B, 6'h00, 0, 1, MS, 4);
    add(6'h08, 6'h00, 0, 1, F1, 5); add(6'h08, 6'h00, 0, 0, DEC, 5);  // ADDI
    add(6'h08, 6'h00, 0, 0, EXI, 5); add(6'h08, 6'h00, 0, 0, WI, 5);
    add(6'h00, 6'h00, 0, 1, F1, 6); add(6'h00, 6'h00, 0, 0, DEC, 6);  // SLL
    add(6'h00, 6'h00, 0, 0, EXS, 6); add(6'h00, 6'h00, 0, 0, WR, 6);
    add(6'h00, 6'h00, 0, 0, F0, 7);

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].fn, vecs[i].eq, vecs[i].ack);
      chk($sformatf("vec%0d outputs", i), 32'(act1), 32'(vecs[i].exp));
      chk($sformatf("vec%0d instr_count", i), instr_count, 32'(vecs[i].cnt));
      tick();
    end
    // 7 retirements in a 2-bit counter wrap to 3
    chk("small instr_count wrap", 32'(t_instr_count), 32'd3);

    // Timeout: MEM_TIMEOUT=4 instance halts after 4 unacknowledged FETCH cycles
    do_reset();
    drive(6'h00, 6'h20, 0, 0); tick();
    for (int k = 0; k < 4; k++) begin
      drive(6'h00, 6'h20, 0, 0);
      chk($sformatf("timeout wait%0d small", k), 32'(act2), 32'(F0));
      chk($sformatf("timeout wait%0d main", k), 32'(act1), 32'(F0));
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      drive(6'h00, 6'h20, 0, 1'(k % 2));
      chk($sformatf("halt cycle%0d", k), 32'(act2), 32'(H));
      tick();
    end
    rst = 1'b1;
    #1 chk("bus_error cleared by rst", 32'(t_bus_error), 32'd0);
    do_reset();

    // Ack on the edge the timer would expire wins
    drive(6'h00, 6'h20, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin drive(6'h00, 6'h20, 0, 0); tick(); end
    drive(6'h00, 6'h20, 0, 1);
    chk("ack at limit fetch", 32'(act2), 32'(F1));
    tick();
    drive(6'h00, 6'h20, 0, 0);
    chk("ack at limit decode", 32'(act2), 32'(DEC));

    // Reset during SW MEM wait
    do_reset();
    drive(6'h2B, 6'h00, 0, 0); tick();
    drive(6'h2B, 6'h00, 0, 1); tick();
    drive(6'h2B, 6'h00, 0, 0); tick();
    drive(6'h2B, 6'h00, 0, 0); tick();
    drive(6'h2B, 6'h00, 0, 0);
    chk("sw mem wait", 32'(act1), 32'(MS));
    tick();
    #2 rst = 1'b1;
    #1 chk("async rst outputs", 32'(act1), 32'(Z));
    chk("async rst count", instr_count, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    drive(6'h2B, 6'h00, 0, 0);
    chk("restart idle", 32'(act1), 32'(Z));
    tick();
    drive(6'h2B, 6'h00, 0, 0);
    chk("restart fetch", 32'(act1), 32'(F0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS core. It replaces single-cycle decode with an FSM that shares one ALU and one unified instruction/data memory port across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- It drives datapath mux selects, register enables and a req/ack memory handshake, and counts retired instructions.
- It supports the same ISA subset as the core: R-type ADD/SUB/AND/OR/SLT/SLL/SRA/SRL, ADDI, LW, SW, BEQ.
- Opcode, funct and ALU op encodings come from defines.vh.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles mem_req may wait for mem_ack before a bus error.
- CNT_WIDTH, 32: width of instr_count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26]. Valid from DECODE onward.
- funct  in  6  IR[5:0].
- equal  in  1  register-file rs==rt compare from the datapath.
- mem_ack  in  1  memory completes the current request.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe; qualified by mem_req.
- mem_addr_sel  out  1  0=PC, 1=ALU-out register.
- ir_en  out  1  load instruction register.
- pc_en  out  1  load PC.
- pc_sel  out  1  0=live ALU result, 1=ALU-out register.
- alu_op  out  4  ALU_* code.
- alu_a_sel  out  2  0=PC, 1=REG(rs), 2=SHAMT.
- alu_b_sel  out  2  0=REG(rt), 1=const 4, 2=IMM, 3=IMM<<2.
- rd_en  out  1  register-file write enable.
- rd_addr_sel  out  1  RD_SEL_RT / RD_SEL_RD.
- rd_data_sel  out  1  RD_DATA_SEL_ALU / RD_DATA_SEL_MEM.
- illegal  out  1  one-cycle pulse on an invalid opcode or funct.
- bus_error  out  1  sticky; set on memory timeout.
- instr_count  out  CNT_WIDTH  retired-instruction counter.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs are decoded combinationally from state, opcode and funct, plus registered timer, counter and bus_error.
- Reset (async) forces: state=IDLE, timer=0, instr_count=0, bus_error=0. All outputs read 0 while rst is high and in IDLE.
- Any unused select is driven 0, never X.
- IDLE: always goes to FETCH on the next edge.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0, alu_a_sel=PC, alu_b_sel=4, alu_op=ADD.
  - When mem_ack=1 at an edge: ir_en=1, pc_en=1, pc_sel=0, next state DECODE.
- DECODE: alu_a_sel=PC, alu_b_sel=IMM<<2, alu_op=ADD (the ALU-out register captures the branch target).
  - Valid opcode -> EXEC.
  - Invalid opcode -> illegal=1, go to FETCH; the instruction is not retired.
- EXEC by opcode:
  - R-type: alu_a_sel=REG, or SHAMT for SLL/SRA/SRL; alu_b_sel=REG; alu_op per funct -> WB. Invalid funct -> illegal=1, go to FETCH; not retired.
  - ADDI, LW, SW: alu_a_sel=REG, alu_b_sel=IMM, alu_op=ADD. ADDI -> WB; LW/SW -> MEM.
  - BEQ: alu_op=SUB, alu_a_sel=REG, alu_b_sel=REG; pc_en=equal, pc_sel=1. Retires and goes to FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(SW).
  - On mem_ack: LW -> WB. SW retires and goes to FETCH.
- WB: rd_en=1.
  - R-type: rd_addr_sel=RD, rd_data_sel=ALU.
  - ADDI: rd_addr_sel=RT, rd_data_sel=ALU.
  - LW: rd_addr_sel=RT, rd_data_sel=MEM.
  - Retires and goes to FETCH.
- Retire: instr_count increments by 1 on the retiring edge and wraps modulo 2^CNT_WIDTH.
- Cycle counts with zero-wait memory (ack in the same cycle as req):
  - BEQ: 3
  - SW, ADDI, R-type: 4
  - LW: 5
  - invalid: 2
  - Each memory wait cycle adds 1.
- Handshake rules:
  - mem_req, mem_we and mem_addr_sel stay stable while waiting.
  - mem_req deasserts in the cycle after ack.
  - mem_ack is ignored when mem_req=0.
- Timeout:
  - The timer clears on entry to FETCH/MEM and increments each cycle mem_req=1 without ack.
  - If the timer reaches MEM_TIMEOUT without ack -> bus_error=1, state HALT.
  - An ack arriving on the same edge the timer reaches MEM_TIMEOUT wins (no error).
  - HALT: all outputs 0 except bus_error=1; it is left only by reset.
- Reset mid-transaction: mem_req drops asynchronously and no pc_en/ir_en/rd_en occurs. Operation resumes at IDLE -> FETCH.

Test Plan:
- Reset, then ADD with 0-wait memory -> states IDLE,FETCH,DECODE,EXEC,WB; rd_en=1 only in WB with rd_addr_sel=RD; instr_count 0->1 after WB.
- LW with mem_ack delayed 3 cycles in both FETCH and MEM -> mem_req held with stable mem_addr_sel; 11 cycles FETCH..WB; rd_data_sel=MEM.
- BEQ with equal=1, then equal=0 -> pc_en=1/pc_sel=1 in EXEC only when equal=1; both complete in 3 cycles; instr_count +2.
- opcode=0x3F, then R-type with funct=0x3F -> illegal pulses once each; no rd_en or mem_req after DECODE/EXEC; instr_count unchanged.
- MEM_TIMEOUT=4, mem_ack never asserted -> bus_error=1 after 4 wait cycles; HALT persists 20 cycles; cleared only by rst.
- rst asserted mid-MEM of SW -> mem_req=0 immediately; no write; restart passes IDLE then FETCH.
